// File: rtl/des_decrypt_iter.sv
// Iterative DES decryptor: one Feistel round per clock, subkeys K16..K1 produced
// on the fly by rotating the latched C/D halves right before each round.
module des_sbox #(
    parameter logic [255:0] LUT = '0
) (
    input  logic [5:0] din,
    output logic [3:0] dout
);
    logic [5:0] idx;

    // Row is the outer bit pair, column the inner four; entry 0 sits at the LUT MSB.
    always_comb begin
        idx  = {din[5], din[0], din[4:1]};
        dout = LUT[{~idx, 2'b11} -: 4];
    end
endmodule

module des_decrypt_iter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] data_in,
    input  logic [63:0] key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] data_out
);
    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    localparam int unsigned IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    localparam int unsigned FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
    localparam int unsigned E_T [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,  8,  9, 10, 11,
        12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
        22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
    localparam int unsigned P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
    localparam int unsigned PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int unsigned PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10, 23, 19, 12,  4,
        26,  8, 16,  7, 27, 20, 13,  2, 41, 52, 31, 37, 47, 55, 30, 40,
        51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    localparam logic [255:0] S1_T = 256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
    localparam logic [255:0] S2_T = 256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
    localparam logic [255:0] S3_T = 256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
    localparam logic [255:0] S4_T = 256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
    localparam logic [255:0] S5_T = 256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
    localparam logic [255:0] S6_T = 256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
    localparam logic [255:0] S7_T = 256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
    localparam logic [255:0] S8_T = 256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;

    // Table entries use DES numbering: DES bit k of a W-bit word is x[W-k].
    function automatic logic [63:0] ip_perm(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int unsigned i = 0; i < 64; i++) y[63 - i] = x[64 - IP_T[i]];
        return y;
    endfunction

    function automatic logic [63:0] fp_perm(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int unsigned i = 0; i < 64; i++) y[63 - i] = x[64 - FP_T[i]];
        return y;
    endfunction

    function automatic logic [47:0] e_exp(input logic [31:0] x);
        logic [47:0] y;
        y = '0;
        for (int unsigned i = 0; i < 48; i++) y[47 - i] = x[32 - E_T[i]];
        return y;
    endfunction

    function automatic logic [31:0] p_perm(input logic [31:0] x);
        logic [31:0] y;
        y = '0;
        for (int unsigned i = 0; i < 32; i++) y[31 - i] = x[32 - P_T[i]];
        return y;
    endfunction

    function automatic logic [55:0] pc1_perm(input logic [63:0] x);
        logic [55:0] y;
        y = '0;
        for (int unsigned i = 0; i < 56; i++) y[55 - i] = x[64 - PC1_T[i]];
        return y;
    endfunction

    function automatic logic [47:0] pc2_perm(input logic [55:0] x);
        logic [47:0] y;
        y = '0;
        for (int unsigned i = 0; i < 48; i++) y[47 - i] = x[56 - PC2_T[i]];
        return y;
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] x, input logic [1:0] n);
        case (n)
            2'd1:    return {x[0], x[27:1]};
            2'd2:    return {x[1:0], x[27:2]};
            default: return x;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] l_q, l_d, r_q, r_d;
    logic [27:0] kc_q, kc_d, kd_q, kd_d;
    logic [63:0] dout_q, dout_d;

    logic [1:0]  rot;
    logic [27:0] kc_rot, kd_rot;
    logic [47:0] subkey, sbox_in;
    logic [31:0] sbox_out, f_out, r_next;

    des_sbox #(.LUT(S1_T)) s1 (.din(sbox_in[47:42]), .dout(sbox_out[31:28]));
    des_sbox #(.LUT(S2_T)) s2 (.din(sbox_in[41:36]), .dout(sbox_out[27:24]));
    des_sbox #(.LUT(S3_T)) s3 (.din(sbox_in[35:30]), .dout(sbox_out[23:20]));
    des_sbox #(.LUT(S4_T)) s4 (.din(sbox_in[29:24]), .dout(sbox_out[19:16]));
    des_sbox #(.LUT(S5_T)) s5 (.din(sbox_in[23:18]), .dout(sbox_out[15:12]));
    des_sbox #(.LUT(S6_T)) s6 (.din(sbox_in[17:12]), .dout(sbox_out[11:8]));
    des_sbox #(.LUT(S7_T)) s7 (.din(sbox_in[11:6]),  .dout(sbox_out[7:4]));
    des_sbox #(.LUT(S8_T)) s8 (.din(sbox_in[5:0]),   .dout(sbox_out[3:0]));

    // Right-rotation amounts undo the encrypt left shifts, walking K16 -> K1.
    always_comb begin
        case (cnt_q)
            4'd0:                rot = 2'd0;
            4'd1, 4'd8, 4'd15:   rot = 2'd1;
            default:             rot = 2'd2;
        endcase
        kc_rot  = rotr(kc_q, rot);
        kd_rot  = rotr(kd_q, rot);
        subkey  = pc2_perm({kc_rot, kd_rot});
        sbox_in = e_exp(r_q) ^ subkey;
        f_out   = p_perm(sbox_out);
        r_next  = l_q ^ f_out;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        l_d     = l_q;
        r_d     = r_q;
        kc_d    = kc_q;
        kd_d    = kd_q;
        dout_d  = dout_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    {l_d, r_d}   = ip_perm(data_in);
                    {kc_d, kd_d} = pc1_perm(key);
                    cnt_d        = '0;
                    state_d      = ROUND;
                end
            end
            ROUND: begin
                l_d   = r_q;
                r_d   = r_next;
                kc_d  = kc_rot;
                kd_d  = kd_rot;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    dout_d  = fp_perm({r_next, r_q});
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            l_q     <= '0;
            r_q     <= '0;
            kc_q    <= '0;
            kd_q    <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            l_q     <= l_d;
            r_q     <= r_d;
            kc_q    <= kc_d;
            kd_q    <= kd_d;
            dout_q  <= dout_d;
        end
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        data_out  = dout_q;
    end
endmodule

// File: tb/tb_des_decrypt_iter.sv
// Scoreboard bench for des_decrypt_iter: a textbook DES model (encrypt/decrypt with a
// precomputed left-shift key schedule) supplies expected plaintexts and latencies.
module tb_des_decrypt_iter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] data_in = '0;
    logic [63:0] key = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] data_out;

    always #5 clk = ~clk;

    des_decrypt_iter dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .key(key), .out_valid(out_valid),
        .out_ready(out_ready), .data_out(data_out)
    );

    int IP_T[$] = {58,50,42,34,26,18,10,2,60,52,44,36,28,20,12,4,62,54,46,38,30,22,14,6,
                   64,56,48,40,32,24,16,8,57,49,41,33,25,17,9,1,59,51,43,35,27,19,11,3,
                   61,53,45,37,29,21,13,5,63,55,47,39,31,23,15,7};
    int FP_T[$] = {40,8,48,16,56,24,64,32,39,7,47,15,55,23,63,31,38,6,46,14,54,22,62,30,
                   37,5,45,13,53,21,61,29,36,4,44,12,52,20,60,28,35,3,43,11,51,19,59,27,
                   34,2,42,10,50,18,58,26,33,1,41,9,49,17,57,25};
    int E_T[$]  = {32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
                   16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
    int P_T[$]  = {16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                   2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
    int PC1_T[$] = {57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                    63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4};
    int PC2_T[$] = {14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                    41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
    int SHIFTS[16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    logic [255:0] SBOX [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

    // Output DES bit j (1..n) is input DES bit t[j-1]; result is right-aligned.
    function automatic logic [63:0] pick(input logic [63:0] src, input int src_w, input int t[$]);
        logic [63:0] res = '0;
        int n = t.size();
        for (int j = 0; j < n; j++) res[n - 1 - j] = src[src_w - t[j]];
        return res;
    endfunction

    function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] kk);
        logic [63:0]  tmp;
        logic [47:0]  x;
        logic [31:0]  s = '0;
        logic [5:0]   six;
        logic [255:0] tbl;
        int           row, col;
        tmp = pick({32'd0, r}, 32, E_T);
        x = tmp[47:0] ^ kk;
        for (int g = 0; g < 8; g++) begin
            six = x[47 - 6 * g -: 6];
            row = 2 * int'(six[5]) + int'(six[0]);
            col = int'(six[4:1]);
            tbl = SBOX[g];
            s = {s[27:0], tbl[255 - 4 * (row * 16 + col) -: 4]};
        end
        tmp = pick({32'd0, s}, 32, P_T);
        return tmp[31:0];
    endfunction

    function automatic logic [63:0] des_model(input logic [63:0] k, input logic [63:0] blk, input bit decrypt);
        logic [63:0] tmp;
        logic [55:0] w;
        logic [27:0] c, d;
        logic [47:0] ks [16];
        logic [31:0] l, r, t;
        tmp = pick(k, 64, PC1_T);
        c = tmp[55:28];
        d = tmp[27:0];
        for (int n = 0; n < 16; n++) begin
            w = {c, c} << SHIFTS[n];
            c = w[55:28];
            w = {d, d} << SHIFTS[n];
            d = w[55:28];
            tmp = pick({8'd0, c, d}, 56, PC2_T);
            ks[n] = tmp[47:0];
        end
        tmp = pick(blk, 64, IP_T);
        l = tmp[63:32];
        r = tmp[31:0];
        for (int n = 0; n < 16; n++) begin
            t = r;
            r = l ^ feistel(r, decrypt ? ks[15 - n] : ks[n]);
            l = t;
        end
        return pick({r, l}, 64, FP_T);
    endfunction

    typedef struct {
        logic [63:0] exp;
        int          acc;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int outputs_seen = 0;
    int expected_outputs = 0;
    bit rnd_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: pops an expectation when out_valid first appears, then watches the hold.
    logic        seen = 1'b0;
    logic [63:0] held = '0;
    exp_t        cur;
    always @(negedge clk) begin
        if (!rst_n) begin
            seen = 1'b0;
        end else if (out_valid) begin
            if (!seen) begin
                seen = 1'b1;
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_output actual=%h required=no_output", data_out);
                end else begin
                    cur = sb.pop_front();
                    check({cur.tag, "_latency"}, 64'(cyc + 1 - cur.acc), 64'd17);
                    check({cur.tag, "_data"}, data_out, cur.exp);
                    outputs_seen++;
                end
                held = data_out;
            end else begin
                check("hold_stable", data_out, held);
            end
            check("in_ready_in_done", 64'(in_ready), 64'd0);
            if (out_ready) seen = 1'b0;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Returns at the negedge before the accepting edge; keep leaves in_valid high.
    task automatic send(input logic [63:0] k, input logic [63:0] ct, input logic [63:0] exp,
                        input string tag, input bit keep, output int acc);
        int budget = 0;
        @(negedge clk);
        in_valid = 1'b1;
        key = k;
        data_in = ct;
        while (!in_ready && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL %s_accept_timeout actual=in_ready_low required=in_ready_high", tag);
            in_valid = 1'b0;
            acc = -1;
            return;
        end
        acc = cyc + 1;
        sb.push_back('{exp, acc, tag});
        expected_outputs++;
        if (!keep) begin
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge clk);
        while ((sb.size() != 0 || !in_ready) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0 || !in_ready) begin
            checks++;
            failures++;
            $display("FAIL %s_drain_timeout actual=pending_%0d required=pending_0", tag, sb.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] k_std, c_std, p_std, k, pt;
        int a1, a2;
        k_std = 64'h133457799BBCDFF1;
        c_std = 64'h85E813540F0AB405;
        p_std = 64'h0123456789ABCDEF;

        repeat (3) @(negedge clk);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_data_out", data_out, 64'd0);
        rst_n = 1'b1;

        send(k_std, c_std, p_std, "vec_std", 1'b0, a1);
        wait_idle("vec_std");
        send(64'd0, 64'h8CA64DE9C1B123A7, 64'd0, "vec_zero", 1'b0, a1);
        wait_idle("vec_zero");
        send(k_std ^ 64'h0101010101010101, c_std, p_std, "vec_parity", 1'b0, a1);
        wait_idle("vec_parity");

        // Stall in DONE with in_valid/data/key scrambled throughout ROUND.
        @(posedge clk);
        #1 out_ready = 1'b0;
        k = {$urandom, $urandom};
        pt = {$urandom, $urandom};
        send(k, des_model(k, pt, 1'b0), pt, "stall", 1'b1, a1);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            in_valid = 1'($urandom);
            data_in = {$urandom, $urandom};
            key = {$urandom, $urandom};
            check("in_ready_in_round", 64'(in_ready), 64'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 out_ready = 1'b1;
        wait_idle("stall");

        // Reset mid-block: the in-flight block must vanish.
        send(k_std, c_std, p_std, "reset_victim", 1'b0, a1);
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_in_ready", 64'(in_ready), 64'd1);
        check("midreset_out_valid", 64'(out_valid), 64'd0);
        check("midreset_data_out", data_out, 64'd0);
        expected_outputs -= sb.size();
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        send(k_std, c_std, p_std, "after_reset", 1'b0, a1);
        wait_idle("after_reset");

        // Back-to-back with in_valid held high.
        k = {$urandom, $urandom};
        pt = {$urandom, $urandom};
        send(k, des_model(k, pt, 1'b0), pt, "b2b_first", 1'b1, a1);
        k = {$urandom, $urandom};
        pt = {$urandom, $urandom};
        send(k, des_model(k, pt, 1'b0), pt, "b2b_second", 1'b1, a2);
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("b2b_spacing", 64'(a2 - a1), 64'd18);
        wait_idle("b2b");

        rnd_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            k = {$urandom, $urandom};
            pt = {$urandom, $urandom};
            send(k, des_model(k, pt, 1'b0), pt, "rand", 1'($urandom), a1);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_idle("rand");
        rnd_ready = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;

        repeat (5) @(negedge clk);
        check("output_count", 64'(outputs_seen), 64'(expected_outputs));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/des_decrypt_iter.md
DES_DECRYPT_ITER -- requirements
Module: des_decrypt_iter

Interface
REQ-001 Parameters SHALL be none; all widths are fixed by the DES standard.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  ciphertext/key pair offered.
REQ-005 in_ready  output  1  block can accept a new pair.
REQ-006 data_in  input  64  ciphertext, bit 63 = DES bit 1.
REQ-007 key  input  64  DES key, bit 63 = DES bit 1; parity bits (DES bits 8,16,...,64) ignored.
REQ-008 out_valid  output  1  plaintext available.
REQ-009 out_ready  input  1  consumer accepts plaintext.
REQ-010 data_out  output  64  recovered plaintext, bit 63 = DES bit 1.

Function
REQ-011 Block SHALL be a three-state FSM: IDLE, ROUND, DONE.
REQ-012 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-013 IDLE, in_valid=1: accept in the same cycle; latch L0||R0 = IP(data_in) and C||D = PC-1(key); round counter = 0; go to ROUND.
REQ-014 IDLE, in_valid=0: no state change.
REQ-015 ROUND SHALL execute exactly one Feistel round per cycle: L' = R, R' = L xor f(R, Kn).
REQ-016 Rounds SHALL use subkeys in the order K16 down to K1.
REQ-017 Decrypt key schedule: before the round at counter i (0..15), C and D SHALL each rotate right by 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 for i = 0..15.
REQ-018 Kn SHALL be PC-2 of the rotated C||D for that round.
REQ-019 No rotation before round 0; K16 equals PC-2(PC-1(key)).
REQ-020 f SHALL be E-expansion of R (32->48), xor Kn, then eight 6-bit groups into the team's s1..s8 S-box modules, then P permutation.
REQ-021 S-box group 1 (bits 47:42) SHALL feed s1; group 8 (bits 5:0) SHALL feed s8.
REQ-022 Each raw 6-bit group SHALL drive the S-box input directly; no row/column reordering.
REQ-023 After the round at counter 15, data_out SHALL load FP(R16||L16) (final swap included); go to DONE.
REQ-024 Latency: accept at cycle T, out_valid high from cycle T+17.
REQ-025 DONE with out_ready=0: out_valid and data_out SHALL hold stable.
REQ-026 DONE with out_ready=1: handshake completes; go to IDLE; in_ready high next cycle (minimum 18 cycles per block).
REQ-027 in_valid, data_in and key changes outside IDLE SHALL be ignored; the block uses only the latched state.
REQ-028 Round counter SHALL be 4 bits and wrap from 15 to 0 only on entry to DONE.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE, in_ready=1, out_valid=0, data_out=0, and clear the counter, L, R, C and D, regardless of state.
REQ-030 A reset during ROUND or DONE SHALL discard the in-flight block; no partial output SHALL appear after reset release.

Verification
REQ-031 key=133457799BBCDFF1, data_in=85E813540F0AB405 -> data_out=0123456789ABCDEF, out_valid at T+17.
REQ-032 key=0, data_in=8CA64DE9C1B123A7 -> data_out=0000000000000000.
REQ-033 key=133457799BBCDFF1 with parity bits flipped, data_in=85E813540F0AB405 -> data_out=0123456789ABCDEF.
REQ-034 Hold out_ready=0 for 10 cycles in DONE, and toggle in_valid/data_in during ROUND -> data_out stable, in_ready=0 throughout, one output only.
REQ-035 Assert rst_n=0 at round 7, release, then run vector REQ-031 -> no spurious out_valid; correct result at T+17.
REQ-036 Two back-to-back blocks with out_ready=1 and in_valid held high -> second accept 18 cycles after the first; both outputs correct.
